program_loader: RTL



---
 rtl/program_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: boot-time image loader sitting in front of the processor core.
// Accepts a length word N, then N data words, on a valid/ready stream. The data
// words are written to memory at sequential addresses starting at START_ADDR,
// and the address wraps modulo 2^ADDR_W. The core is held in reset until the
// whole image has been written.
// Build option: define LOADER_CHECKSUM_EN to require a trailing checksum word.
// The checksum is the 16-bit wrapping sum of the data words.
module program_loader #(
   parameter int ADDR_W     = 12,
   parameter int START_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [15:0]       i_data,
   output logic              o_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [15:0]       o_mem_data,
   output logic              o_core_rst,
   output logic              o_done,
   output logic              o_error,
   output logic [ADDR_W:0]   o_count
);

   typedef enum logic [2:0] {
      LEN,
      LOAD,
`ifdef LOADER_CHECKSUM_EN
      CHK,
`endif
      FLUSH,
      DONE,
      ERR
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t POST_LOAD = CHK;
`else
   localparam state_t POST_LOAD = FLUSH;
`endif

   localparam logic [ADDR_W-1:0] START   = ADDR_W'(START_ADDR);
   localparam int unsigned       MAX_LEN = 32'd1 << ADDR_W;

   state_t              state, stateNext;
   logic                readyQ, readyNext;
   logic                weQ;
   logic [ADDR_W-1:0]   addrQ;
   logic [15:0]         dataQ;
   logic [ADDR_W:0]     countQ;
   logic [ADDR_W:0]     lenQ;
   logic                xfer;
   logic                lastWord;
   logic                tooLong;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0]         sumQ;
`endif

   assign xfer     = i_valid & readyQ;
   assign lastWord = (countQ + (ADDR_W+1)'(1)) == lenQ;
   assign tooLong  = 32'(i_data) > MAX_LEN;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= LEN;
      else     state <= stateNext;
   end

   // Next-state selection and registered-ready precompute
   always_comb begin
      stateNext = state;
      readyNext = 1'b0;
      case (state)
         LEN: begin
            if (xfer) begin
               if (i_data == 16'd0) stateNext = POST_LOAD;
               else if (tooLong)    stateNext = ERR;
               else                 stateNext = LOAD;
            end
         end
         LOAD: begin
            if (xfer && lastWord) stateNext = POST_LOAD;
         end
`ifdef LOADER_CHECKSUM_EN
         CHK: begin
            if (xfer) stateNext = (i_data == sumQ) ? FLUSH : ERR;
         end
`endif
         FLUSH:   stateNext = DONE;
         DONE:    stateNext = DONE;
         ERR:     stateNext = ERR;
         default: stateNext = ERR;
      endcase
`ifdef LOADER_CHECKSUM_EN
      readyNext = (stateNext == LEN) || (stateNext == LOAD) || (stateNext == CHK);
`else
      readyNext = (stateNext == LEN) || (stateNext == LOAD);
`endif
   end

   // Datapath: length latch, memory write port, word counter and running sum
   always_ff @(posedge clk) begin
      if (rst) begin
         readyQ <= 1'b0;
         weQ    <= 1'b0;
         addrQ  <= START;
         dataQ  <= '0;
         countQ <= '0;
         lenQ   <= '0;
`ifdef LOADER_CHECKSUM_EN
         sumQ   <= '0;
`endif
      end else begin
         readyQ <= readyNext;
         weQ    <= 1'b0;
         if (state == LEN && xfer) lenQ <= (ADDR_W+1)'(i_data);
         if (state == LOAD && xfer) begin
            weQ    <= 1'b1;
            addrQ  <= START + countQ[ADDR_W-1:0];
            dataQ  <= i_data;
            countQ <= countQ + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
            sumQ   <= sumQ + i_data;
`endif
         end
      end
   end

   assign o_ready    = readyQ;
   assign o_mem_we   = weQ;
   assign o_mem_addr = addrQ;
   assign o_mem_data = dataQ;
   assign o_count    = countQ;
   assign o_done     = (state == DONE);
   assign o_error    = (state == ERR);
   assign o_core_rst = (state != DONE);

endmodule
